fetch_decode_alu: RTL and testbench

- Fetch/decode/execute slice of the double-accumulator processor: program counter, unified word memory, instruction register and 16-bit ALU.
- The PC addresses memory. Memory read data feeds the IR, which splits the instruction into register and immediate fields.
- The ALU operands come from the surrounding datapath (register file and operand muxes, outside this block). The ALU result is the PC's next value.

---
 rtl/fetch_decode_alu_pkg.sv | 24 ++
 rtl/fetch_decode_alu_if.sv | 37 +++
 rtl/fdx_alu.sv | 25 ++
 rtl/fetch_decode_alu.sv | 69 ++++++
 tb/tb_fetch_decode_alu.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_alu_pkg.sv
// Shared definitions for the fetch/decode/execute slice: word width,
// instruction field positions and ALU operation encodings.
package fetch_decode_alu_pkg;

  localparam int WORD_W = 16;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 10;
  localparam int RD_MSB   = 9;
  localparam int RD_LSB   = 8;
  localparam int RS1_MSB  = 7;
  localparam int RS1_LSB  = 6;
  localparam int RS2_MSB  = 5;
  localparam int RS2_LSB  = 4;
  localparam int IMM1_MSB = 5;
  localparam int IMM2_MSB = 7;
  localparam int IMM3_MSB = 9;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/fetch_decode_alu_if.sv
// Control, operand and decoded-field bundle between the surrounding
// datapath/controller (master) and the fetch/decode/ALU slice (slave).
interface fetch_decode_alu_if;
  import fetch_decode_alu_pkg::*;

  logic        pc_write;
  logic        mem_write;
  word_t       mem_din;
  logic        ir_load;
  word_t       alu_a;
  word_t       alu_b;
  logic        alu_op;
  word_t       pc;
  word_t       mem_dout;
  word_t       alu_out;
  logic        alu_zero;
  logic [5:0]  opcode;
  logic [1:0]  reg_dest;
  logic [1:0]  reg1;
  logic [1:0]  reg2;
  logic [5:0]  imm1;
  logic [7:0]  imm2;
  logic [9:0]  imm3;

  modport master (
    output pc_write, mem_write, mem_din, ir_load, alu_a, alu_b, alu_op,
    input  pc, mem_dout, alu_out, alu_zero,
           opcode, reg_dest, reg1, reg2, imm1, imm2, imm3
  );

  modport slave (
    input  pc_write, mem_write, mem_din, ir_load, alu_a, alu_b, alu_op,
    output pc, mem_dout, alu_out, alu_zero,
           opcode, reg_dest, reg1, reg2, imm1, imm2, imm3
  );

endinterface

// File: rtl/fdx_alu.sv
// Combinational 16-bit add/subtract ALU; results wrap modulo 2^WORD_W.
module fdx_alu
  import fetch_decode_alu_pkg::*;
(
  input  word_t i_a,
  input  word_t i_b,
  input  logic  i_op,
  output word_t o_y,
  output logic  o_zero
);

  logic signed [WORD_W-1:0] w_a;
  logic signed [WORD_W-1:0] w_b;
  logic signed [WORD_W-1:0] w_y;

  assign w_a = i_a;
  assign w_b = i_b;

  // Two's-complement wrap falls out of keeping the result at WORD_W bits.
  assign w_y = (i_op == ALU_SUB) ? (w_a - w_b) : (w_a + w_b);

  assign o_y    = w_y;
  assign o_zero = (w_y == '0);

endmodule

// File: rtl/fetch_decode_alu.sv
// Program counter, single-port word memory with registered read,
// instruction register with field slicing, and the ALU feeding the PC.
module fetch_decode_alu
  import fetch_decode_alu_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic               CLK,
  input  logic               RST,
  fetch_decode_alu_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  word_t          r_mem [DEPTH];
  word_t          r_pc;
  word_t          r_ir;
  word_t          r_mem_dout;
  word_t          w_alu_out;
  logic           w_alu_zero;
  logic [AW-1:0]  w_addr;

  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  // Upper pc bits are ignored, so addresses alias modulo DEPTH.
  assign w_addr = r_pc[AW-1:0];

  fdx_alu u_alu (
    .i_a    (bus.alu_a),
    .i_b    (bus.alu_b),
    .i_op   (bus.alu_op),
    .o_y    (w_alu_out),
    .o_zero (w_alu_zero)
  );

  // All updates sample pre-edge values: the write and the read use the
  // old pc, and the IR takes the old read data (read-old-data behaviour).
  // Memory is only written outside reset and is never cleared by it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_mem_dout <= '0;
    end else begin
      if (bus.pc_write)  r_pc <= w_alu_out;
      if (bus.ir_load)   r_ir <= r_mem_dout;
      if (bus.mem_write) r_mem[w_addr] <= bus.mem_din;
      r_mem_dout <= r_mem[w_addr];
    end
  end

  assign bus.pc       = r_pc;
  assign bus.mem_dout = r_mem_dout;
  assign bus.alu_out  = w_alu_out;
  assign bus.alu_zero = w_alu_zero;

  // Overlapping slices are deliberate; decode picks fields per opcode.
  assign bus.opcode   = r_ir[OPC_MSB:OPC_LSB];
  assign bus.reg_dest = r_ir[RD_MSB:RD_LSB];
  assign bus.reg1     = r_ir[RS1_MSB:RS1_LSB];
  assign bus.reg2     = r_ir[RS2_MSB:RS2_LSB];
  assign bus.imm1     = r_ir[IMM1_MSB:0];
  assign bus.imm2     = r_ir[IMM2_MSB:0];
  assign bus.imm3     = r_ir[IMM3_MSB:0];

endmodule

// File: tb/tb_fetch_decode_alu.sv
// Bench for fetch_decode_alu: ALU vector table plus hand-written sequences
// for PC stepping, memory latency, IR decode, overlap and async reset.
module tb_fetch_decode_alu;
  import fetch_decode_alu_pkg::*;

  logic CLK;
  logic RST;

  fetch_decode_alu_if bus ();

  fetch_decode_alu #(.DEPTH(1024), .INIT_FILE("")) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string name;
    word_t val;
  } exp_t;

  typedef struct {
    word_t a;
    word_t b;
    logic  op;
    word_t y;
    logic  z;
  } alu_vec_t;

  exp_t     exp_q[$];
  alu_vec_t vecs[6];
  int       n_checks = 0;
  int       n_pass   = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_val(input string name, input word_t val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check_next(input word_t act);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty actual=%h required=<queued expectation>", act);
    end else begin
      e = exp_q.pop_front();
      if (act === e.val) n_pass++;
      else $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
    end
  endtask

  task automatic set_pc(input word_t v);
    bus.alu_a    = v;
    bus.alu_b    = 16'h0000;
    bus.alu_op   = ALU_ADD;
    bus.pc_write = 1'b1;
    tick();
    bus.pc_write = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0003, 16'h0004, ALU_ADD, 16'h0007, 1'b0};
    vecs[1] = '{16'h0032, 16'h0032, ALU_ADD, 16'h0064, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, ALU_ADD, 16'h0000, 1'b1};
    vecs[3] = '{16'h0000, 16'h0001, ALU_SUB, 16'hFFFF, 1'b0};
    vecs[4] = '{16'h012C, 16'h0014, ALU_SUB, 16'h0118, 1'b0};
    vecs[5] = '{16'h1234, 16'h1234, ALU_SUB, 16'h0000, 1'b1};

    RST           = 1'b1;
    bus.pc_write  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_din   = 16'h0000;
    bus.ir_load   = 1'b0;
    bus.alu_a     = 16'h0000;
    bus.alu_b     = 16'h0000;
    bus.alu_op    = ALU_ADD;

    // Reset state
    repeat (2) tick();
    RST = 1'b0;
    expect_val("reset_pc", 16'h0000);        check_next(bus.pc);
    expect_val("reset_mem_dout", 16'h0000);  check_next(bus.mem_dout);
    expect_val("reset_opcode", 16'h0000);    check_next({10'd0, bus.opcode});
    expect_val("reset_imm3", 16'h0000);      check_next({6'd0, bus.imm3});

    // ALU vector table, combinational (no edge between drive and sample)
    for (int i = 0; i < 6; i++) begin
      bus.alu_a  = vecs[i].a;
      bus.alu_b  = vecs[i].b;
      bus.alu_op = vecs[i].op;
      expect_val($sformatf("alu_out_%0d", i), vecs[i].y);
      expect_val($sformatf("alu_zero_%0d", i), {15'd0, vecs[i].z});
      #1;
      check_next(bus.alu_out);
      check_next({15'd0, bus.alu_zero});
    end

    // PC increment through the ALU
    for (int i = 1; i <= 3; i++) begin
      bus.alu_a    = bus.pc;
      bus.alu_b    = 16'h0001;
      bus.alu_op   = ALU_ADD;
      bus.pc_write = 1'b1;
      expect_val($sformatf("pc_inc_%0d", i), 16'(i));
      tick();
      bus.pc_write = 1'b0;
      check_next(bus.pc);
    end
    expect_val("pc_hold", 16'h0003);
    repeat (2) tick();
    check_next(bus.pc);

    // Memory write: old data on the write edge, new data one edge later
    set_pc(16'h0002);
    tick();
    bus.mem_write = 1'b1;
    bus.mem_din   = 16'h1234;
    expect_val("mem_rdw_old", 16'h0000);
    tick();
    bus.mem_write = 1'b0;
    check_next(bus.mem_dout);
    expect_val("mem_readback", 16'h1234);
    tick();
    check_next(bus.mem_dout);

    // IR decode of 0x96A5
    bus.mem_write = 1'b1;
    bus.mem_din   = 16'h96A5;
    tick();
    bus.mem_write = 1'b0;
    tick();
    bus.ir_load = 1'b1;
    tick();
    bus.ir_load = 1'b0;
    expect_val("opcode", 16'h0025);    check_next({10'd0, bus.opcode});
    expect_val("reg_dest", 16'h0002);  check_next({14'd0, bus.reg_dest});
    expect_val("reg1", 16'h0002);      check_next({14'd0, bus.reg1});
    expect_val("reg2", 16'h0002);      check_next({14'd0, bus.reg2});
    expect_val("imm1", 16'h0025);      check_next({10'd0, bus.imm1});
    expect_val("imm2", 16'h00A5);      check_next({8'd0, bus.imm2});
    expect_val("imm3", 16'h02A5);      check_next({6'd0, bus.imm3});

    // pc_write, mem_write and ir_load together: everything sees the old pc
    bus.alu_a     = 16'h0005;
    bus.alu_b     = 16'h0000;
    bus.alu_op    = ALU_ADD;
    bus.pc_write  = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_din   = 16'hC3C3;
    bus.ir_load   = 1'b1;
    tick();
    bus.pc_write  = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_load   = 1'b0;
    expect_val("simul_pc", 16'h0005);        check_next(bus.pc);
    expect_val("simul_mem_dout", 16'h96A5);  check_next(bus.mem_dout);
    expect_val("simul_imm2", 16'h00A5);      check_next({8'd0, bus.imm2});

    // Asynchronous reset between edges; a write during reset is dropped
    #2;
    RST = 1'b1;
    #1;
    expect_val("async_pc", 16'h0000);        check_next(bus.pc);
    expect_val("async_opcode", 16'h0000);    check_next({10'd0, bus.opcode});
    expect_val("async_imm3", 16'h0000);      check_next({6'd0, bus.imm3});
    expect_val("async_mem_dout", 16'h0000);  check_next(bus.mem_dout);
    bus.mem_write = 1'b1;
    bus.mem_din   = 16'hDEAD;
    tick();
    bus.mem_write = 1'b0;
    RST = 1'b0;
    expect_val("write_during_reset", 16'h0000);
    tick();
    check_next(bus.mem_dout);

    // Retention after reset, read through an aliased address
    set_pc(16'h0402);
    expect_val("alias_pc", 16'h0402);        check_next(bus.pc);
    expect_val("retained_word", 16'hC3C3);
    tick();
    check_next(bus.mem_dout);

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
